// File: rtl/lsu_commit_arb.sv
// ============================================================================
// Module      : lsu_commit_arb
// Description : Merges LSU load/store commit streams through per-stream skid
//               FIFOs and a round-robin arbiter that keeps multi-beat loads
//               contiguous. Optional perf counters: LSU_COMMIT_PERF_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module lsu_commit_arb #(
    parameter int NUM_THREADS = 4,
    parameter int NW_BITS     = 2,
    parameter int NR_BITS     = 5,
    parameter int BUF_DEPTH   = 2
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      ld_valid,
    output logic                      ld_ready,
    input  logic [NW_BITS-1:0]        ld_wid,
    input  logic [NUM_THREADS-1:0]    ld_tmask,
    input  logic [31:0]               ld_pc,
    input  logic [NR_BITS-1:0]        ld_rd,
    input  logic                      ld_wb,
    input  logic                      ld_eop,
    input  logic [NUM_THREADS*32-1:0] ld_data,
    input  logic                      st_valid,
    output logic                      st_ready,
    input  logic [NW_BITS-1:0]        st_wid,
    input  logic [NUM_THREADS-1:0]    st_tmask,
    input  logic [31:0]               st_pc,
    input  logic [NR_BITS-1:0]        st_rd,
    input  logic                      st_wb,
    input  logic                      st_eop,
    input  logic [NUM_THREADS*32-1:0] st_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [NW_BITS-1:0]        out_wid,
    output logic [NUM_THREADS-1:0]    out_tmask,
    output logic [31:0]               out_pc,
    output logic [NR_BITS-1:0]        out_rd,
    output logic                      out_wb,
    output logic                      out_eop,
    output logic [NUM_THREADS*32-1:0] out_data
`ifdef LSU_COMMIT_PERF_EN
    ,
    output logic [31:0]               perf_ld_beats,
    output logic [31:0]               perf_st_beats,
    output logic [31:0]               perf_stalls
`endif
);

    localparam int DW = NUM_THREADS * 32;
    localparam int BW = NW_BITS + NUM_THREADS + 32 + NR_BITS + 2 + DW;
    localparam int PW = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
    localparam int CW = PW + 1;

    // Index 0 is the load stream, index 1 the store stream.
    logic          w_in_valid [2];
    logic [BW-1:0] w_in_beat  [2];
    logic          w_fifo_rdy [2];
    logic [BW-1:0] w_head     [2];
    logic          w_nonempty [2];
    logic          w_pop      [2];

    logic          r_rr_ptr;
    logic          r_lock;
    logic          r_out_valid;
    logic [BW-1:0] r_out_beat;

    logic          w_pick_ld;
    logic          w_pick_st;
    logic          w_can_load;
    logic [BW-1:0] w_grant_beat;

    assign w_in_valid[0] = ld_valid;
    assign w_in_valid[1] = st_valid;
    assign w_in_beat[0]  = {ld_wid, ld_tmask, ld_pc, ld_rd, ld_wb, ld_eop, ld_data};
    assign w_in_beat[1]  = {st_wid, st_tmask, st_pc, st_rd, st_wb, st_eop, st_data};
    assign ld_ready      = w_fifo_rdy[0];
    assign st_ready      = w_fifo_rdy[1];

    for (genvar g = 0; g < 2; g++) begin : g_fifo
        logic [BW-1:0] r_mem [BUF_DEPTH];
        logic [PW-1:0] r_rd_ptr;
        logic [PW-1:0] r_wr_ptr;
        logic [CW-1:0] r_count;
        logic          w_push;

        assign w_fifo_rdy[g] = (r_count < CW'(BUF_DEPTH));
        assign w_push        = w_in_valid[g] & w_fifo_rdy[g];
        assign w_head[g]     = r_mem[r_rd_ptr];
        assign w_nonempty[g] = (r_count != '0);

        always_ff @(posedge clk) begin
            if (w_push && !reset) begin
                r_mem[r_wr_ptr] <= w_in_beat[g];
            end
        end

        always_ff @(posedge clk) begin
            if (reset) begin
                r_rd_ptr <= '0;
                r_wr_ptr <= '0;
                r_count  <= '0;
            end else begin
                if (w_push) begin
                    r_wr_ptr <= r_wr_ptr + 1'b1;
                end
                if (w_pop[g]) begin
                    r_rd_ptr <= r_rd_ptr + 1'b1;
                end
                case ({w_push, w_pop[g]})
                    2'b10:   r_count <= r_count + 1'b1;
                    2'b01:   r_count <= r_count - 1'b1;
                    default: r_count <= r_count;
                endcase
            end
        end
    end

    // A held lock parks the grant on loads even when the load FIFO runs dry.
    always_comb begin
        w_pick_ld = 1'b0;
        w_pick_st = 1'b0;
        if (r_lock) begin
            w_pick_ld = w_nonempty[0];
        end else if (w_nonempty[0] && w_nonempty[1]) begin
            w_pick_ld = ~r_rr_ptr;
            w_pick_st = r_rr_ptr;
        end else begin
            w_pick_ld = w_nonempty[0];
            w_pick_st = w_nonempty[1];
        end
    end

    assign w_can_load   = ~r_out_valid | out_ready;
    assign w_pop[0]     = w_pick_ld & w_can_load;
    assign w_pop[1]     = w_pick_st & w_can_load;
    assign w_grant_beat = w_pop[0] ? w_head[0] : w_head[1];

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rr_ptr    <= 1'b0;
            r_lock      <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_beat  <= '0;
        end else begin
            if (w_pop[1]) begin
                r_rr_ptr <= 1'b0;
            end else if (w_pop[0]) begin
                if (w_head[0][DW]) begin
                    r_rr_ptr <= 1'b1;
                    r_lock   <= 1'b0;
                end else begin
                    r_lock   <= 1'b1;
                end
            end
            if (w_pop[0] || w_pop[1]) begin
                r_out_valid <= 1'b1;
                r_out_beat  <= w_grant_beat;
            end else if (out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign out_valid = r_out_valid;
    assign out_data  = r_out_beat[DW-1:0];
    assign out_eop   = r_out_beat[DW];
    assign out_wb    = r_out_beat[DW+1];
    assign out_rd    = r_out_beat[DW+2 +: NR_BITS];
    assign out_pc    = r_out_beat[DW+2+NR_BITS +: 32];
    assign out_tmask = r_out_beat[DW+34+NR_BITS +: NUM_THREADS];
    assign out_wid   = r_out_beat[DW+34+NR_BITS+NUM_THREADS +: NW_BITS];

`ifdef LSU_COMMIT_PERF_EN
    logic        r_out_src;
    logic [31:0] r_perf_ld;
    logic [31:0] r_perf_st;
    logic [31:0] r_perf_stall;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_out_src    <= 1'b0;
            r_perf_ld    <= '0;
            r_perf_st    <= '0;
            r_perf_stall <= '0;
        end else begin
            if (w_pop[0] || w_pop[1]) begin
                r_out_src <= w_pop[1];
            end
            if (r_out_valid && out_ready) begin
                if (r_out_src) begin
                    r_perf_st <= r_perf_st + 32'd1;
                end else begin
                    r_perf_ld <= r_perf_ld + 32'd1;
                end
            end
            if (r_out_valid && !out_ready) begin
                r_perf_stall <= r_perf_stall + 32'd1;
            end
        end
    end

    assign perf_ld_beats = r_perf_ld;
    assign perf_st_beats = r_perf_st;
    assign perf_stalls   = r_perf_stall;
`endif

endmodule

`default_nettype wire

// File: tb/tb_lsu_commit_arb.sv
// ============================================================================
// Module      : tb_lsu_commit_arb
// Description : Directed scoreboard bench for lsu_commit_arb.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_lsu_commit_arb;

    localparam int NT  = 4;
    localparam int NWB = 2;
    localparam int NRB = 5;
    localparam int BD  = 2;
    localparam int BW  = NWB + NT + 32 + NRB + 2 + NT * 32;

    logic            clk = 1'b0;
    logic            reset;
    logic            ld_valid, ld_ready, ld_wb, ld_eop;
    logic [NWB-1:0]  ld_wid;
    logic [NT-1:0]   ld_tmask;
    logic [31:0]     ld_pc;
    logic [NRB-1:0]  ld_rd;
    logic [NT*32-1:0] ld_data;
    logic            st_valid, st_ready, st_wb, st_eop;
    logic [NWB-1:0]  st_wid;
    logic [NT-1:0]   st_tmask;
    logic [31:0]     st_pc;
    logic [NRB-1:0]  st_rd;
    logic [NT*32-1:0] st_data;
    logic            out_valid, out_ready, out_wb, out_eop;
    logic [NWB-1:0]  out_wid;
    logic [NT-1:0]   out_tmask;
    logic [31:0]     out_pc;
    logic [NRB-1:0]  out_rd;
    logic [NT*32-1:0] out_data;
`ifdef LSU_COMMIT_PERF_EN
    logic [31:0]     perf_ld_beats, perf_st_beats, perf_stalls;
`endif

    lsu_commit_arb #(
        .NUM_THREADS(NT), .NW_BITS(NWB), .NR_BITS(NRB), .BUF_DEPTH(BD)
    ) dut (
        .clk(clk), .reset(reset),
        .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_wid(ld_wid), .ld_tmask(ld_tmask),
        .ld_pc(ld_pc), .ld_rd(ld_rd), .ld_wb(ld_wb), .ld_eop(ld_eop), .ld_data(ld_data),
        .st_valid(st_valid), .st_ready(st_ready), .st_wid(st_wid), .st_tmask(st_tmask),
        .st_pc(st_pc), .st_rd(st_rd), .st_wb(st_wb), .st_eop(st_eop), .st_data(st_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_wid(out_wid), .out_tmask(out_tmask),
        .out_pc(out_pc), .out_rd(out_rd), .out_wb(out_wb), .out_eop(out_eop), .out_data(out_data)
`ifdef LSU_COMMIT_PERF_EN
        , .perf_ld_beats(perf_ld_beats), .perf_st_beats(perf_st_beats), .perf_stalls(perf_stalls)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    logic [BW-1:0] ld_q[$];
    logic [BW-1:0] st_q[$];
    bit            order_q[$];
    int            hs_cyc_q[$];
    bit            ld_fired, st_fired;
    logic [BW-1:0] mon_exp;
    bit            mon_src;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [BW-1:0] pack_out();
        return {out_wid, out_tmask, out_pc, out_rd, out_wb, out_eop, out_data};
    endfunction

    // Scoreboard: stores are tagged by pc[31]; order of sources is logged.
    always @(negedge clk) begin
        if (!reset && out_valid && out_ready) begin
            mon_src = out_pc[31];
            chk("sb_has_expected", (mon_src ? st_q.size() : ld_q.size()) != 0, 1);
            if ((mon_src ? st_q.size() : ld_q.size()) != 0) begin
                mon_exp = mon_src ? st_q.pop_front() : ld_q.pop_front();
                chk("sb_beat", pack_out(), mon_exp);
            end
            order_q.push_back(mon_src);
            hs_cyc_q.push_back(cyc);
        end
    end

    task automatic set_ld(input int seq, input bit eop);
        ld_valid = 1'b1;
        ld_wid   = NWB'(seq);
        ld_tmask = NT'(seq + 1);
        ld_pc    = 32'h0000_1000 + 32'(seq) * 4;
        ld_rd    = NRB'(seq + 1);
        ld_wb    = 1'b1;
        ld_eop   = eop;
        ld_data  = {32'hD000_0000 + 32'(seq), 32'hC000_0000 + 32'(seq),
                    32'hB000_0000 + 32'(seq), 32'hA000_0000 + 32'(seq)};
    endtask

    task automatic set_st(input int seq);
        st_valid = 1'b1;
        st_wid   = NWB'(seq + 2);
        st_tmask = ~NT'(seq + 1);
        st_pc    = 32'h8000_0000 + 32'(seq) * 4;
        st_rd    = '0;
        st_wb    = 1'b0;
        st_eop   = 1'b1;
        st_data  = {32'h5400_0000 + 32'(seq), 32'h5300_0000 + 32'(seq),
                    32'h5200_0000 + 32'(seq), 32'h5100_0000 + 32'(seq)};
    endtask

    task automatic tick();
        @(negedge clk);
        ld_fired = !reset && ld_valid && ld_ready;
        st_fired = !reset && st_valid && st_ready;
        if (ld_fired) ld_q.push_back({ld_wid, ld_tmask, ld_pc, ld_rd, ld_wb, ld_eop, ld_data});
        if (st_fired) st_q.push_back({st_wid, st_tmask, st_pc, st_rd, st_wb, st_eop, st_data});
        @(posedge clk);
        #1;
    endtask

    task automatic clear_sb();
        ld_q.delete();
        st_q.delete();
        order_q.delete();
        hs_cyc_q.delete();
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        ld_valid  = 1'b0;
        st_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        clear_sb();
    endtask

    task automatic drain();
        int n;
        ld_valid  = 1'b0;
        st_valid  = 1'b0;
        out_ready = 1'b1;
        n = 0;
        while ((ld_q.size() + st_q.size()) != 0 && n < 30) begin
            tick();
            n++;
        end
        repeat (2) tick();
        chk("drain_done", ld_q.size() + st_q.size(), 0);
    endtask

    task automatic run_stream(input int nld, input int nst, input int s0, input int slen);
        int ls, ss;
        logic [255:0] held;
        ls = 0;
        ss = 0;
        held = '0;
        if (nld > 0) set_ld(0, 1'b1); else ld_valid = 1'b0;
        if (nst > 0) set_st(0);       else st_valid = 1'b0;
        for (int c = 0; c < 200; c++) begin
            if (c == s0) begin
                out_ready = 1'b0;
                held = {out_valid, pack_out()};
            end
            if (c == s0 + slen) out_ready = 1'b1;
            tick();
            if (ld_fired) begin ls++; if (ls < nld) set_ld(ls, 1'b1); else ld_valid = 1'b0; end
            if (st_fired) begin ss++; if (ss < nst) set_st(ss);       else st_valid = 1'b0; end
            if (s0 >= 0 && c >= s0 && c < s0 + slen) chk("stall_hold", {out_valid, pack_out()}, held);
            if (s0 >= 0 && c == s0 + slen - 1) begin
                chk("stall_ld_ready", ld_ready, 0);
                chk("stall_st_ready", st_ready, 0);
            end
            if (ls >= nld && ss >= nst && c >= s0 + slen) break;
        end
        drain();
    endtask

    task automatic check_order(input int nld, input int nst);
        int bad, m;
        bit e;
        bad = 0;
        m = (nld < nst) ? nld : nst;
        for (int i = 0; i < order_q.size(); i++) begin
            e = (i < 2 * m) ? bit'(i % 2) : (nst > nld);
            if (order_q[i] != e) bad++;
        end
        chk("order_len", order_q.size(), nld + nst);
        chk("order_alt", bad, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bit exp_lock [4];
        int bad;

        // Reset state
        do_reset();
        chk("rst_out_valid", out_valid, 0);
        chk("rst_ld_ready", ld_ready, 1);
        chk("rst_st_ready", st_ready, 1);
        chk("rst_out_data", out_data, 0);
        chk("rst_out_pc", out_pc, 0);

        // Single load: two-cycle latency, one cycle wide
        set_ld(2, 1'b1);
        ld_rd   = 5'd3;
        ld_data = {4{32'hA5A5A5A5}};
        tick();
        chk("single_fire", ld_fired, 1);
        ld_valid = 1'b0;
        chk("single_early", out_valid, 0);
        tick();
        chk("single_valid", out_valid, 1);
        chk("single_rd", out_rd, 3);
        chk("single_data", out_data, {4{32'hA5A5A5A5}});
        chk("single_eop", out_eop, 1);
        tick();
        chk("single_width", out_valid, 0);
        drain();

        // Alternation at full rate
        do_reset();
        run_stream(6, 6, -1, 0);
        check_order(6, 6);
        chk("thru_span", hs_cyc_q[hs_cyc_q.size()-1] - hs_cyc_q[0], 11);

        // Multi-beat load stays contiguous; store waits through a load gap
        do_reset();
        set_ld(0, 1'b0);
        set_st(0);
        tick();
        set_ld(1, 1'b0);
        st_valid = 1'b0;
        tick();
        ld_valid = 1'b0;
        tick();
        set_ld(2, 1'b1);
        tick();
        chk("lock_store_waits", out_valid, 0);
        drain();
        exp_lock = '{1'b0, 1'b0, 1'b0, 1'b1};
        chk("lock_len", order_q.size(), 4);
        bad = 0;
        for (int i = 0; i < 4 && i < order_q.size(); i++) if (order_q[i] != exp_lock[i]) bad++;
        chk("lock_order", bad, 0);

        // Back-pressure for 5 cycles while both streams run
        do_reset();
        run_stream(10, 10, 3, 5);
        check_order(10, 10);
`ifdef LSU_COMMIT_PERF_EN
        chk("perf_stalls", perf_stalls, 5);
`endif

        // Reset while locked with both FIFOs full
        do_reset();
        out_ready = 1'b0;
        set_ld(0, 1'b0);
        set_st(0);
        for (int i = 1; i < 5; i++) begin
            tick();
            if (ld_fired) set_ld(i, 1'b0);
            if (st_fired) set_st(i);
        end
        chk("full_ld_ready", ld_ready, 0);
        chk("full_st_ready", st_ready, 0);
        reset    = 1'b1;
        st_valid = 1'b0;
        @(posedge clk);
        #1;
        reset    = 1'b0;
        ld_valid = 1'b0;
        clear_sb();
        chk("rstmid_out_valid", out_valid, 0);
        chk("rstmid_ld_ready", ld_ready, 1);
        chk("rstmid_st_ready", st_ready, 1);
        out_ready = 1'b1;
        set_st(7);
        tick();
        st_valid = 1'b0;
        drain();
        chk("rstmid_len", order_q.size(), 1);
        if (order_q.size() > 0) chk("rstmid_store_first", order_q[0], 1);

        // Uneven mix: 7 loads, 4 stores
        do_reset();
        run_stream(7, 4, -1, 0);
        check_order(7, 4);
`ifdef LSU_COMMIT_PERF_EN
        chk("perf_ld_beats", perf_ld_beats, 7);
        chk("perf_st_beats", perf_st_beats, 4);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
